// File: rtl/vga_scanout.sv
// VGA 640x480 scanout of a 320x240 4bpp frame buffer with 2x2 replication; 3-clock counter-to-pin latency.
// Optional VGA_PALETTE_EN adds a 16x12-bit palette register file looked up at the output stage.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int FB_WIDTH = 320
) (
  input  logic        vga_clk,
  input  logic        vga_rst,
  output logic [16:0] vga_pixel_addr,
  input  logic [3:0]  vga_pixel_data,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_de,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        frame_start
`ifdef VGA_PALETTE_EN
  ,
  input  logic        pal_we,
  input  logic [3:0]  pal_idx,
  input  logic [11:0] pal_rgb
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        act0, hs0, vs0, fs0;
  logic [16:0] x17, y17, lin_addr, addr_d;
  // flag bits: {frame_start, vsync_active, hsync_active, display_enable}
  logic [3:0]  flg1_q, flg2_q;
  logic        hs_q, vs_q, de_q, fs_q;
  logic [11:0] rgb_q, rgb_d, color;

  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
    end
  end

  assign act0 = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hs0  = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
  assign vs0  = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
  assign fs0  = (h_cnt_q == '0) && (v_cnt_q == '0);

  // Halving both counters gives the 2x2 replication into the half-resolution buffer.
  assign x17 = {8'd0, h_cnt_q[9:1]};
  assign y17 = {8'd0, v_cnt_q[9:1]};

  generate
    if (FB_WIDTH == 320) begin : g_mul_shift
      assign lin_addr = (y17 << 8) + (y17 << 6) + x17;
    end else begin : g_mul_generic
      assign lin_addr = y17 * 17'(FB_WIDTH) + x17;
    end
  endgenerate

  assign addr_d = act0 ? lin_addr : '0;

`ifdef VGA_PALETTE_EN
  logic [11:0] pal_q [16];

  // Lookup reads the pre-write contents when the same entry is written this cycle.
  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      for (int i = 0; i < 16; i++) pal_q[i] <= {4'(i), 4'(i), 4'(i)};
    end else if (pal_we) begin
      pal_q[pal_idx] <= pal_rgb;
    end
  end

  assign color = pal_q[vga_pixel_data];
`else
  assign color = {vga_pixel_data, vga_pixel_data, vga_pixel_data};
`endif

  assign rgb_d = flg2_q[0] ? color : '0;

  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      h_cnt_q        <= '0;
      v_cnt_q        <= '0;
      vga_pixel_addr <= '0;
      flg1_q         <= '0;
      flg2_q         <= '0;
      hs_q           <= 1'b1;
      vs_q           <= 1'b1;
      de_q           <= 1'b0;
      fs_q           <= 1'b0;
      rgb_q          <= '0;
    end else begin
      h_cnt_q        <= h_cnt_d;
      v_cnt_q        <= v_cnt_d;
      vga_pixel_addr <= addr_d;
      flg1_q         <= {fs0, vs0, hs0, act0};
      flg2_q         <= flg1_q;
      hs_q           <= ~flg2_q[1];
      vs_q           <= ~flg2_q[2];
      de_q           <= flg2_q[0];
      fs_q           <= flg2_q[3];
      rgb_q          <= rgb_d;
    end
  end

  assign vga_hsync   = hs_q;
  assign vga_vsync   = vs_q;
  assign vga_de      = de_q;
  assign frame_start = fs_q;
  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: full horizontal timing with a shortened vertical frame, frame-position reference model.
module tb_vga_scanout;

  localparam int HT    = 800;
  localparam int VA    = 10;
  localparam int VF    = 3;
  localparam int VS    = 2;
  localparam int VB    = 5;
  localparam int VT    = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        vga_clk = 1'b0;
  logic        vga_rst = 1'b0;
  logic [16:0] vga_pixel_addr;
  logic [3:0]  pix_data = 4'd0;
  logic        vga_hsync, vga_vsync, vga_de, frame_start;
  logic [3:0]  vga_r, vga_g, vga_b;

  int errors = 0;
  int checks = 0;
  int k;
  int mode = 0;
  bit run = 1'b0;
  logic [3:0] tab [64];

`ifdef VGA_PALETTE_EN
  logic        pal_we = 1'b0;
  logic [3:0]  pal_idx = 4'd0;
  logic [11:0] pal_rgb = 12'd0;
  logic [11:0] pal_m [16];
  bit          pal_done = 1'b0;
`endif

  vga_scanout #(
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .vga_clk        (vga_clk),
    .vga_rst        (vga_rst),
    .vga_pixel_addr (vga_pixel_addr),
    .vga_pixel_data (pix_data),
    .vga_hsync      (vga_hsync),
    .vga_vsync      (vga_vsync),
    .vga_de         (vga_de),
    .vga_r          (vga_r),
    .vga_g          (vga_g),
    .vga_b          (vga_b),
    .frame_start    (frame_start)
`ifdef VGA_PALETTE_EN
    ,
    .pal_we         (pal_we),
    .pal_idx        (pal_idx),
    .pal_rgb        (pal_rgb)
`endif
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", nm, act, exp, k);
    end
  endtask

  function automatic logic [3:0] memf(input logic [16:0] a);
    return (mode == 0) ? a[3:0] : tab[a[5:0]];
  endfunction

  function automatic logic [16:0] model_addr(input int h, input int v);
    if (h < 640 && v < VA) return 17'((v / 2) * 320 + h / 2);
    return 17'd0;
  endfunction

  function automatic logic [11:0] color(input logic [3:0] d);
`ifdef VGA_PALETTE_EN
    return pal_m[d];
`else
    return {d, d, d};
`endif
  endfunction

  // Cycles since reset release; the counters sit at frame position k.
  always @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) k <= 0;
    else         k <= k + 1;
  end

  // Synchronous-read frame buffer model.
  always @(posedge vga_clk) pix_data <= memf(vga_pixel_addr);

  int p, h, v;
  logic [16:0] e_addr;
  logic        e_hs, e_vs, e_de, e_fs;
  logic [11:0] e_rgb;
  bit prev_hs, prev_vs, prev_de, hs_in, vs_in, de_in;
  int hs_run, vs_run, de_run, hs_fall_k, vs_fall_k, fs_k;

  always @(negedge vga_clk) begin
    if (run) begin
      e_addr = '0;
      if (!vga_rst && k >= 1) begin
        p = (k - 1) % FRAME;
        e_addr = model_addr(p % HT, p / HT);
      end
      e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_fs = 1'b0; e_rgb = '0;
      if (!vga_rst && k >= 3) begin
        p = (k - 3) % FRAME;
        h = p % HT;
        v = p / HT;
        e_de  = (h < 640) && (v < VA);
        e_hs  = !(h >= 656 && h < 752);
        e_vs  = !(v >= VA + VF && v < VA + VF + VS);
        e_fs  = (p == 0);
        e_rgb = e_de ? color(memf(model_addr(h, v))) : 12'd0;
      end
      chk("cycle", {vga_pixel_addr, vga_hsync, vga_vsync, vga_de, frame_start, vga_r, vga_g, vga_b},
          {e_addr, e_hs, e_vs, e_de, e_fs, e_rgb});

      if (!vga_rst && k >= 1) begin
        p = (k - 1) % FRAME;
        case (p)
          0:            chk("addr_0_0", vga_pixel_addr, 0);
          2:            chk("addr_2_0", vga_pixel_addr, 1);
          639:          chk("addr_639_0", vga_pixel_addr, 319);
          640:          chk("addr_640_0", vga_pixel_addr, 0);
          2 * HT:       chk("addr_0_2", vga_pixel_addr, 320);
          9 * HT + 639: chk("addr_639_9", vga_pixel_addr, 1599);
          default: ;
        endcase
      end

      if (!vga_rst && mode == 0 && k >= 3 && k <= 6) begin
        chk("lat_de", vga_de, 1);
        chk("lat_r", vga_r, (k >= 5) ? 1 : 0);
      end
      if (!vga_rst && mode == 1 && k >= 3 && (k - 3) % FRAME == 700)
        chk("blank_rgb_with_data_f", {vga_r, vga_g, vga_b}, 0);
`ifdef VGA_PALETTE_EN
      if (!vga_rst && mode == 1 && pal_done && k >= 3) begin
        if ((k - 3) % FRAME == 2) chk("pal_idx5", {vga_r, vga_g, vga_b}, 12'hF00);
        if ((k - 3) % FRAME == 4) chk("pal_idx6", {vga_r, vga_g, vga_b}, 12'h666);
      end
`endif

      if (vga_rst) begin
        prev_hs = 1; prev_vs = 1; prev_de = 0;
        hs_in = 0; vs_in = 0; de_in = 0;
        hs_fall_k = -1; vs_fall_k = -1; fs_k = -1;
      end else begin
        if (!vga_hsync) begin
          if (prev_hs) begin
            if (hs_fall_k >= 0) chk("hs_period", k - hs_fall_k, HT);
            else                chk("hs_first_fall", k, 659);
            hs_fall_k = k; hs_run = 0; hs_in = 1;
          end
          hs_run++;
        end else if (!prev_hs && hs_in) chk("hs_width", hs_run, 96);

        if (!vga_vsync) begin
          if (prev_vs) begin
            if (vs_fall_k >= 0) chk("vs_period", k - vs_fall_k, FRAME);
            else                chk("vs_first_fall", k, (VA + VF) * HT + 3);
            vs_fall_k = k; vs_run = 0; vs_in = 1;
          end
          vs_run++;
        end else if (!prev_vs && vs_in) chk("vs_width", vs_run, 1600);

        if (vga_de) begin
          if (!prev_de) begin de_run = 0; de_in = 1; end
          de_run++;
        end else if (prev_de && de_in) chk("de_width", de_run, 640);

        if (frame_start) begin
          chk("fs_on_de_rise", {vga_de, prev_de}, 2'b10);
          if (fs_k >= 0) chk("fs_period", k - fs_k, FRAME);
          else           chk("fs_first", k, 3);
          fs_k = k;
        end
        prev_hs = vga_hsync; prev_vs = vga_vsync; prev_de = vga_de;
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) tab[i] = 4'($urandom_range(0, 15));
    tab[0] = 4'hF;
    tab[1] = 4'h5;
    tab[2] = 4'h6;
`ifdef VGA_PALETTE_EN
    for (int i = 0; i < 16; i++) pal_m[i] = {4'(i), 4'(i), 4'(i)};
`endif
    #1 vga_rst = 1'b1;
    run = 1'b1;
    repeat (3) @(posedge vga_clk);
    #2 vga_rst = 1'b0;

    // Mid-frame reset at line 6, pixel 300 of the second frame.
    while (k < FRAME + 6 * HT + 300) begin
      @(posedge vga_clk);
      #1;
    end
    #1 vga_rst = 1'b1;
    #1;
    chk("rst_async_addr", vga_pixel_addr, 0);
    chk("rst_async_hsync", vga_hsync, 1);
    chk("rst_async_vsync", vga_vsync, 1);
    chk("rst_async_de", vga_de, 0);
    chk("rst_async_rgb", {vga_r, vga_g, vga_b}, 0);
    chk("rst_async_fs", frame_start, 0);
    repeat (5) @(posedge vga_clk);
    mode = 1;
    #2 vga_rst = 1'b0;

`ifdef VGA_PALETTE_EN
    while (k < VA * HT + 100) begin
      @(posedge vga_clk);
      #1;
    end
    @(negedge vga_clk);
    #1;
    pal_we = 1'b1; pal_idx = 4'd5; pal_rgb = 12'hF00;
    @(negedge vga_clk);
    #1;
    pal_we = 1'b0;
    pal_m[5] = 12'hF00;
    pal_done = 1'b1;
`endif

    while (k < 2 * FRAME + 50) begin
      @(posedge vga_clk);
      #1;
    end
    @(negedge vga_clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
